// File: rtl/video_input_gate.sv
// Frame-locking gate for a DE/VS pixel stream: passes only pixels inside a properly
// framed window, clips over-long lines, flags bad geometry and converts RGB888 to RGB565.
module video_input_gate #(
    parameter int VIDEO_WIDTH  = 1280,
    parameter int VIDEO_HEIGHT = 720
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vs_in,
    input  logic        de_in,
    input  logic [23:0] rgb888_in,
    output logic        vs_out,
    output logic        de_out,
    output logic [15:0] rgb565_out,
    output logic        locked,
    output logic [15:0] frame_cnt,
    output logic        line_err,
    output logic        frame_err
);

    typedef enum logic [1:0] {SEARCH, VSYNC, ACTIVE, VBLANK} state_t;

    localparam logic [11:0] LP_WIDTH  = 12'(VIDEO_WIDTH);
    localparam logic [10:0] LP_HEIGHT = 11'(VIDEO_HEIGHT);

    state_t      r_state;
    state_t      w_next_state;
    logic        r_vs_d;
    logic        r_de_d;
    logic [11:0] r_pix_cnt;
    logic [10:0] r_line_cnt;
    logic        r_en1;
    logic [15:0] r_rgb1;
    logic        r_vs_out;
    logic        r_de_out;
    logic [15:0] r_rgb_out;
    logic        r_line_err;
    logic        r_frame_err;
    logic [15:0] r_frame_cnt;

    logic        w_vs_rise;
    logic        w_vs_fall;
    logic        w_de_rise;
    logic        w_de_fall;
    logic        w_in_frame;
    logic        w_frame_end;
    logic [11:0] w_pix_idx;
    logic        w_en;
    logic        w_unused;

    assign w_vs_rise = vs_in & ~r_vs_d;
    assign w_vs_fall = ~vs_in & r_vs_d;
    assign w_de_rise = de_in & ~r_de_d;
    assign w_de_fall = ~de_in & r_de_d;
    assign w_unused  = ^{rgb888_in[18:16], rgb888_in[9:8], rgb888_in[2:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= SEARCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            SEARCH: if (w_vs_rise) w_next_state = VSYNC;
            VSYNC:  if (w_vs_fall) w_next_state = ACTIVE;
            ACTIVE: begin
                if (w_vs_rise)                     w_next_state = VSYNC;
                else if (r_line_cnt >= LP_HEIGHT)  w_next_state = VBLANK;
            end
            VBLANK: if (w_vs_rise) w_next_state = VSYNC;
            default: w_next_state = SEARCH;
        endcase
    end

    // The pixel index seen on a DE rising edge is zero even though the register clears a clock later.
    always_comb begin
        w_in_frame  = (r_state == ACTIVE) || (r_state == VBLANK);
        w_frame_end = w_in_frame && w_vs_rise;
        w_pix_idx   = w_de_rise ? 12'd0 : r_pix_cnt;
        w_en        = (r_state == ACTIVE) && de_in && (w_pix_idx < LP_WIDTH) && !w_vs_rise;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vs_d      <= 1'b0;
            r_de_d      <= 1'b0;
            r_pix_cnt   <= '0;
            r_line_cnt  <= '0;
            r_line_err  <= 1'b0;
            r_frame_err <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_vs_d <= vs_in;
            r_de_d <= de_in;

            if (r_state == ACTIVE && de_in) begin
                r_pix_cnt <= (w_pix_idx == 12'hFFF) ? w_pix_idx : w_pix_idx + 12'd1;
            end else if (w_de_rise || (r_state == VSYNC && w_vs_fall)) begin
                r_pix_cnt <= '0;
            end

            if (r_state == VSYNC && w_vs_fall) begin
                r_line_cnt <= '0;
            end else if (w_in_frame && w_de_fall && r_line_cnt != 11'h7FF) begin
                r_line_cnt <= r_line_cnt + 11'd1;
            end

            r_line_err  <= (r_state == ACTIVE) && w_de_fall && (r_pix_cnt != LP_WIDTH);
            r_frame_err <= w_frame_end && (r_line_cnt != LP_HEIGHT);
            if (w_frame_end && r_line_cnt == LP_HEIGHT) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    // Two-stage output pipeline; stage 1 shares the edge-detect register for VS.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_en1     <= 1'b0;
            r_rgb1    <= '0;
            r_vs_out  <= 1'b0;
            r_de_out  <= 1'b0;
            r_rgb_out <= '0;
        end else begin
            r_en1     <= w_en;
            r_rgb1    <= w_en ? {rgb888_in[23:19], rgb888_in[15:10], rgb888_in[7:3]} : 16'd0;
            r_vs_out  <= r_vs_d;
            r_de_out  <= r_en1;
            r_rgb_out <= r_en1 ? r_rgb1 : 16'd0;
        end
    end

    assign vs_out     = r_vs_out;
    assign de_out     = r_de_out;
    assign rgb565_out = r_rgb_out;
    assign locked     = w_in_frame;
    assign frame_cnt  = r_frame_cnt;
    assign line_err   = r_line_err;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_video_input_gate.sv
// Randomised frame/line stimulus for video_input_gate, checked every clock against a
// frame-level behavioural model; geometry shrunk to 16x8 to keep runs short.
module tb_video_input_gate;

    localparam int W = 16;
    localparam int H = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vs_in = 1'b0;
    logic        de_in = 1'b0;
    logic [23:0] rgb888_in = '0;
    logic        vs_out;
    logic        de_out;
    logic [15:0] rgb565_out;
    logic        locked;
    logic [15:0] frame_cnt;
    logic        line_err;
    logic        frame_err;

    int vectors = 0;
    int miscompares = 0;
    int errPulses = 0;

    // Model: mode 0 = unsynced, 1 = inside vsync, 2 = inside a framed region
    int          mode, lineCnt, pixIdx, frameCnt;
    bit          prevVs, prevDe, prevEn;
    logic [15:0] prevRgb;
    bit          eVs, eDe, eLock, eLerr, eFerr;
    logic [15:0] eRgb;

    video_input_gate #(.VIDEO_WIDTH(W), .VIDEO_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .vs_in(vs_in), .de_in(de_in), .rgb888_in(rgb888_in),
        .vs_out(vs_out), .de_out(de_out), .rgb565_out(rgb565_out), .locked(locked),
        .frame_cnt(frame_cnt), .line_err(line_err), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] to565(input logic [23:0] p);
        int r, g, b;
        r = int'(p[23:16]);
        g = int'(p[15:8]);
        b = int'(p[7:0]);
        return 16'((r / 8) * 2048 + (g / 4) * 32 + (b / 8));
    endfunction

    task automatic modelReset();
        mode = 0; lineCnt = 0; pixIdx = 0; frameCnt = 0;
        prevVs = 0; prevDe = 0; prevEn = 0; prevRgb = '0;
        eVs = 0; eDe = 0; eLock = 0; eLerr = 0; eFerr = 0; eRgb = '0;
    endtask

    task automatic modelStep();
        bit rise, fall, dRise, dFall, en;
        int idx, lc0;
        if (!rst) begin
            modelReset();
            return;
        end
        eVs = prevVs; eDe = prevEn; eRgb = prevRgb; eLerr = 0; eFerr = 0;
        rise  = vs_in && !prevVs;
        fall  = !vs_in && prevVs;
        dRise = de_in && !prevDe;
        dFall = !de_in && prevDe;
        en    = 0;
        lc0   = lineCnt;
        case (mode)
            0: if (rise) mode = 1;
            1: if (fall) begin mode = 2; lineCnt = 0; pixIdx = 0; end
            default: begin
                idx = dRise ? 0 : pixIdx;
                en  = de_in && (lc0 < H) && (idx < W) && !rise;
                if (de_in) pixIdx = idx + 1;
                if (dFall) begin
                    if (lc0 < H && pixIdx != W) eLerr = 1;
                    if (lineCnt < 2047) lineCnt++;
                end
                if (rise) begin
                    if (lc0 != H) eFerr = 1;
                    else frameCnt = (frameCnt + 1) % 65536;
                    mode = 1;
                end
            end
        endcase
        eLock   = (mode == 2);
        prevVs  = vs_in;
        prevDe  = de_in;
        prevEn  = en;
        prevRgb = en ? to565(rgb888_in) : 16'd0;
    endtask

    task automatic checkAll();
        checkOutput("vs_out",     32'(vs_out),     32'(eVs));
        checkOutput("de_out",     32'(de_out),     32'(eDe));
        checkOutput("rgb565_out", 32'(rgb565_out), 32'(eRgb));
        checkOutput("locked",     32'(locked),     32'(eLock));
        checkOutput("line_err",   32'(line_err),   32'(eLerr));
        checkOutput("frame_err",  32'(frame_err),  32'(eFerr));
        checkOutput("frame_cnt",  32'(frame_cnt),  32'(frameCnt));
        if (line_err === 1'b1 || frame_err === 1'b1) errPulses++;
    endtask

    task automatic applyStimulus(input bit vs, input bit de, input logic [23:0] rgb);
        @(negedge clk);
        vs_in = vs;
        de_in = de;
        rgb888_in = rgb;
        @(posedge clk);
        #1;
        modelStep();
        checkAll();
    endtask

    task automatic sendVsync(input bit deHigh);
        applyStimulus(1'b1, deHigh, 24'($urandom));
        repeat (2) applyStimulus(1'b1, 1'b0, 24'($urandom));
        repeat (2) applyStimulus(1'b0, 1'b0, 24'($urandom));
    endtask

    // rstAt >= 0 drops reset asynchronously mid-line and releases it three pixels later.
    task automatic sendLine(input int len, input int rstAt);
        int gap;
        for (int i = 0; i < len; i++) begin
            if (i == rstAt) begin
                rst = 1'b0;
                #1;
                modelStep();
                checkAll();
            end
            if (rstAt >= 0 && i == rstAt + 3) rst = 1'b1;
            applyStimulus(1'b0, 1'b1, 24'($urandom));
        end
        gap = $urandom_range(2, 4);
        repeat (gap) applyStimulus(1'b0, 1'b0, 24'($urandom));
    endtask

    task automatic sendFrame(input int nLines, input int badLine, input int badLen, input int rstLine);
        for (int l = 0; l < nLines; l++) begin
            sendLine((l == badLine) ? badLen : W, (l == rstLine) ? W / 2 : -1);
        end
    endtask

    initial begin
        modelReset();
        repeat (2) @(negedge clk);
        modelStep();
        checkAll();
        rst = 1'b1;

        // Three clean frames
        errPulses = 0;
        repeat (3) begin
            sendVsync(1'b0);
            sendFrame(H, -1, 0, -1);
        end
        sendVsync(1'b0);
        checkOutput("clean_frames", 32'(frame_cnt), 32'd3);
        checkOutput("clean_errors", 32'(errPulses), 32'd0);

        // Reset mid-line: rest of frame dropped, relock on next vsync
        sendFrame(H, -1, 0, 3);
        checkOutput("rst_unlocked", 32'(locked), 32'd0);
        sendVsync(1'b0);
        sendFrame(H, -1, 0, -1);
        sendVsync(1'b0);
        checkOutput("rst_relock_cnt", 32'(frame_cnt), 32'd1);

        // Over-long line is clipped and flagged, frame still counts
        errPulses = 0;
        sendFrame(H, 2, W + 20, -1);
        sendVsync(1'b0);
        checkOutput("long_line_cnt", 32'(frame_cnt), 32'd2);
        checkOutput("long_line_err", 32'(errPulses), 32'd1);

        // Short frame
        errPulses = 0;
        sendFrame(H - 1, -1, 0, -1);
        sendVsync(1'b0);
        checkOutput("short_frame_cnt", 32'(frame_cnt), 32'd2);
        checkOutput("short_frame_err", 32'(errPulses), 32'd1);

        // Directed colour conversion in the first line of a frame
        applyStimulus(1'b0, 1'b1, 24'hF8FCF8);
        applyStimulus(1'b0, 1'b1, 24'h070307);
        checkOutput("rgb_white", 32'(rgb565_out), 32'h0000FFFF);
        applyStimulus(1'b0, 1'b1, 24'h808080);
        checkOutput("rgb_black_de", 32'(de_out), 32'd1);
        checkOutput("rgb_black", 32'(rgb565_out), 32'h00000000);
        applyStimulus(1'b0, 1'b1, 24'($urandom));
        checkOutput("rgb_grey", 32'(rgb565_out), 32'h00008410);
        for (int i = 4; i < W; i++) applyStimulus(1'b0, 1'b1, 24'($urandom));
        repeat (3) applyStimulus(1'b0, 1'b0, 24'($urandom));
        sendFrame(H - 1, -1, 0, -1);
        sendVsync(1'b0);
        checkOutput("conv_frame_cnt", 32'(frame_cnt), 32'd3);

        // Truncated frame: vsync arrives with DE still high
        errPulses = 0;
        sendFrame(H - 1, -1, 0, -1);
        for (int i = 0; i < W / 2; i++) applyStimulus(1'b0, 1'b1, 24'($urandom));
        sendVsync(1'b1);
        checkOutput("trunc_frame_cnt", 32'(frame_cnt), 32'd3);
        checkOutput("trunc_frame_err", 32'(errPulses), 32'd1);

        // Randomised geometry
        repeat (8) begin
            int nLines, badLine, badLen;
            nLines  = H - 1 + $urandom_range(0, 2);
            badLine = ($urandom_range(0, 1) == 1) ? $urandom_range(0, nLines - 1) : -1;
            badLen  = $urandom_range(1, W + 6);
            sendFrame(nLines, badLine, badLen, -1);
            sendVsync(1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/video_input_gate.md
VIDEO_INPUT_GATE -- requirements
Module: video_input_gate

Interface
REQ-001 SHALL have parameter VIDEO_WIDTH, default 1280: active pixels per line.
REQ-002 SHALL have parameter VIDEO_HEIGHT, default 720: active lines per frame.
REQ-003 SHALL have port clk, input, 1: pixel clock; the block has one clock, and all logic runs on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port vs_in, input, 1: vertical sync, active-high.
REQ-006 SHALL have port de_in, input, 1: data enable, one pixel per clock while high.
REQ-007 SHALL have port rgb888_in, input, 24: pixel data {R[23:16],G[15:8],B[7:0]}.
REQ-008 SHALL have port vs_out, output, 1: vs_in delayed 2 clocks.
REQ-009 SHALL have port de_out, output, 1: gated and clipped data enable, aligned with rgb565_out.
REQ-010 SHALL have port rgb565_out, output, 16: converted pixel.
REQ-011 SHALL have port locked, output, 1: high while in state ACTIVE or VBLANK after the first complete vsync.
REQ-012 SHALL have port frame_cnt, output, 16: count of completed gated frames.
REQ-013 SHALL have port line_err, output, 1: one-clock pulse on a bad line length.
REQ-014 SHALL have port frame_err, output, 1: one-clock pulse on a bad line count.

Function
REQ-015 SHALL register vs_in and de_in once to detect edges: rising edge = current high and previous low; falling edge = current low and previous high.
REQ-016 SHALL implement states SEARCH, VSYNC, ACTIVE, VBLANK; the reset state is SEARCH.
REQ-017 SHALL, in SEARCH, go to VSYNC on a vs_in rising edge and ignore de_in.
REQ-018 SHALL, in VSYNC, go to ACTIVE on a vs_in falling edge and clear the pixel and line counters.
REQ-019 SHALL, in ACTIVE, pass pixels, and on a vs_in rising edge run the frame check (REQ-025) then go to VSYNC.
REQ-020 SHALL use VBLANK for ACTIVE after the line counter reaches VIDEO_HEIGHT: de_in is suppressed, a vs rising edge goes to VSYNC, and the frame check is still run.
REQ-021 SHALL hold a pixel counter pix_cnt, 12 bits: +1 per de_in-high clock in ACTIVE, cleared on each de_in rising edge.
REQ-022 SHALL hold a line counter line_cnt, 11 bits: +1 on each de_in falling edge in ACTIVE/VBLANK, saturating at 2047.
REQ-023 SHALL assert the internal enable only when state is ACTIVE, de_in is high and pix_cnt < VIDEO_WIDTH; pixels beyond VIDEO_WIDTH in a line SHALL be clipped.
REQ-024 SHALL pulse line_err for 1 clock, the clock after a de_in falling edge, when the final pix_cnt != VIDEO_WIDTH; the line SHALL still count.
REQ-025 SHALL perform the frame check on the vs rising edge that ends ACTIVE/VBLANK: pulse frame_err 1 clock if line_cnt != VIDEO_HEIGHT, else increment frame_cnt (wrap 0xFFFF -> 0).
REQ-026 SHALL convert pixels as rgb565 = {R[7:3],G[7:2],B[7:3]}, registered.
REQ-027 SHALL give de_out, rgb565_out and vs_out a fixed latency of exactly 2 clocks from de_in/rgb888_in/vs_in.
REQ-028 SHALL force rgb565_out to 0 when de_out is low.
REQ-029 SHALL, when de_in is high during a vs_in rising edge (truncated frame), stop passing pixels from that clock and run the frame check normally.
REQ-030 SHALL, when reset is released mid-frame, produce no de_out until a full vs high-to-low sequence has been seen.

Reset
REQ-031 SHALL, on rst low, immediately clear state to SEARCH and clear all counters, pipelines, de_out, vs_out, rgb565_out, locked, frame_cnt, line_err and frame_err to 0.
REQ-032 SHALL, on deassertion, resume on the next clk edge; reset mid-line SHALL drop the rest of that frame with no error pulse.

Verification
REQ-033 SHALL cover: reset, then 3 clean 1280x720 frames -> de_out 2 clocks after de_in, 1280 pulses per line, 720 lines, frame_cnt = 3, no error pulses.
REQ-034 SHALL cover: reset released mid-ACTIVE with de_in toggling -> de_out stays 0 until after the next vs falling edge; locked rises on that edge.
REQ-035 SHALL cover: one line of 1300 pixels -> only 1280 de_out pulses, line_err 1 pulse, frame_cnt still increments.
REQ-036 SHALL cover: a frame of 719 lines -> frame_err 1 pulse at the vs rising edge, frame_cnt unchanged.
REQ-037 SHALL cover: pixel 0xF8FC F8 -> rgb565_out 0xFFFF; 0x070307 -> 0x0000; 0x808080 -> 0x8410.
REQ-038 SHALL cover: rst pulsed low mid-frame -> all outputs 0 asynchronously; after release, no output until the next full vsync.
